// File: rtl/seq_detect_ctrl.sv
// Programmable controller around a serial Mealy sequence detector. Holds the
// pattern configuration, arms or stops detection, counts matches and flags
// completion once a target number of matches has been reached.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               z,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  // fill saturates at MAX_LEN-1, which always fits in $clog2(MAX_LEN) bits
  localparam int unsigned        FILL_W   = $clog2(MAX_LEN);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(4'b1001);

  typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic                 w_arm;

  logic [MAX_LEN-1:0]   r_pattern;
  logic [3:0]           r_len;
  logic                 r_overlap;
  logic [CNT_W-1:0]     r_target;
  logic                 r_cfg_err;

  logic [MAX_LEN-2:0]   r_hist;
  logic [FILL_W-1:0]    r_fill;
  logic [CNT_W-1:0]     r_count;

  logic [MAX_LEN-1:0]   w_window;
  logic [MAX_LEN-1:0]   w_mask;
  logic                 w_fill_ok;
  logic                 w_m;
  logic                 w_z;
  logic                 w_hit_target;
  logic                 w_cfg_ok;

  // Newest history bit sits just above the current input, so the low len bits
  // of the window line up with pattern[len-1:0]; len = 1 needs no special case.
  assign w_window  = {r_hist, x};
  assign w_fill_ok = (32'(r_fill) + 32'd1) >= 32'(r_len);
  assign w_m       = x_valid && w_fill_ok && (((w_window ^ r_pattern) & w_mask) == '0);
  assign w_hit_target = (r_target != '0) &&
                        ((CNT_W + 1)'(r_count) + (CNT_W + 1)'(1) == (CNT_W + 1)'(r_target));
  assign w_cfg_ok  = (cfg_len != 4'd0) && (32'(cfg_len) <= MAX_LEN);

  // Select the low r_len bits of the comparison window
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state; abort always beats start and a same-cycle match
  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start && !abort) begin
          w_state_next = StArmed;
          w_arm        = 1'b1;
        end
      end
      StArmed: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (w_z && w_hit_target) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (start) begin
          w_state_next = StArmed;
          w_arm        = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs; z depends combinationally only on x, x_valid and abort
  always_comb begin
    w_z         = (r_state == StArmed) && w_m && !abort;
    z           = w_z;
    busy        = (r_state == StArmed);
    done        = (r_state == StDone);
    match_count = r_count;
    cfg_err     = r_cfg_err;
  end

  // Configuration registers; writes are only taken outside ARMED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= PAT_RST;
      r_len     <= 4'd4;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_cfg_err <= 1'b0;
    end else if (cfg_we && (r_state != StArmed)) begin
      if (w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
        r_cfg_err <= 1'b0;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  // Detection history, fill level and match counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else if (w_arm) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else if ((r_state == StArmed) && x_valid && !abort) begin
      r_hist <= w_window[MAX_LEN-2:0];
      // Non-overlapping mode restarts the search after every match
      if (w_z && !r_overlap) begin
        r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_z && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the detector.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_DONE  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               x;
  logic               x_valid;
  logic               z;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .start      (start),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .z          (z),
    .busy       (busy),
    .done       (done),
    .match_count(match_count),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: bits received since arming (or since the last
  // non-overlapping match), compared against the pattern tail.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_tgt;
  bit                 m_err;
  int                 m_st;
  int                 m_cnt;
  bit                 q[$];

  logic               last_z;
  logic [31:0]        zm;

  task automatic model_reset();
    m_pat = 8'b0000_1001;
    m_len = 4;
    m_ovl = 1'b0;
    m_tgt = 0;
    m_err = 1'b0;
    m_st  = S_IDLE;
    m_cnt = 0;
    q.delete();
  endtask

  function automatic bit model_z();
    if (m_st != S_ARMED || !x_valid || abort) return 1'b0;
    if (q.size() < m_len - 1) return 1'b0;
    if (x != m_pat[0]) return 1'b0;
    for (int i = 1; i < m_len; i++) begin
      if (q[q.size() - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_arm();
    m_st  = S_ARMED;
    m_cnt = 0;
    q.delete();
  endtask

  task automatic model_step(input bit mz);
    if (cfg_we && m_st != S_ARMED) begin
      if (cfg_len == 0 || cfg_len > MAX_LEN) begin
        m_err = 1'b1;
      end else begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        m_tgt = int'(cfg_target);
        m_err = 1'b0;
      end
    end
    case (m_st)
      S_IDLE: if (start && !abort) model_arm();
      S_ARMED: begin
        if (abort) begin
          m_st = S_IDLE;
        end else if (x_valid) begin
          if (mz && !m_ovl) begin
            q.delete();
          end else begin
            q.push_back(x);
            if (q.size() > MAX_LEN - 1) void'(q.pop_front());
          end
          if (mz) begin
            if (m_tgt != 0 && m_cnt + 1 == m_tgt) m_st = S_DONE;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          end
        end
      end
      default: begin
        if (abort) m_st = S_IDLE;
        else if (start) model_arm();
      end
    endcase
  endtask

  // One clock: z checked mid-cycle, registered outputs checked after the edge
  task automatic cyc();
    bit mz;
    @(negedge clk);
    mz = model_z();
    check("z", z, mz);
    last_z = z;
    model_step(mz);
    @(posedge clk);
    #1;
    check("busy", busy, m_st == S_ARMED);
    check("done", done, m_st == S_DONE);
    check("count", match_count, m_cnt);
    check("cfg_err", cfg_err, m_err);
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
    start = 0; abort = 0; x = 0; x_valid = 0;
  endtask

  task automatic cfg_write(input logic [7:0] pat, input int len, input bit ovl, input int tgt);
    cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ovl; cfg_target = 8'(tgt);
    cfg_we = 1; cyc(); cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic do_abort();
    abort = 1; cyc(); abort = 0;
  endtask

  // Feed n bits of s, first bit = s[n-1]; z per bit recorded in zm
  task automatic feed(input logic [31:0] s, input int n, input int gap);
    zm = '0;
    for (int i = 0; i < n; i++) begin
      x = s[n-1-i]; x_valid = 1; cyc();
      zm[i] = last_z;
      x_valid = 0;
      for (int g = 0; g < gap; g++) begin
        x = ~x; cyc();
      end
    end
    x_valid = 0;
  endtask

  localparam logic [31:0] STREAM = 32'b100100100100111011;

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    #2 rst = 1;
    #1;
    check("rst_z", z, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1 rst = 0;

    // Default config, non-overlapping
    do_start();
    feed(STREAM, 18, 0);
    check("t1_zpos", zm, 32'h208);
    check("t1_cnt", match_count, 2);
    check("t1_done", done, 0);

    // Overlapping
    do_abort();
    cfg_write(8'b1001, 4, 1, 0);
    do_start();
    feed(STREAM, 18, 0);
    check("t2_zpos", zm, 32'h1248);
    check("t2_cnt", match_count, 4);

    // Target of two matches
    do_abort();
    cfg_write(8'b1001, 4, 1, 2);
    do_start();
    feed(STREAM, 18, 0);
    check("t3_zpos", zm, 32'h48);
    check("t3_cnt", match_count, 2);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);

    // Illegal lengths rejected, config kept
    cfg_write(8'h00, 0, 0, 0);
    check("t4_err0", cfg_err, 1);
    cfg_write(8'hff, 9, 0, 0);
    check("t4_err9", cfg_err, 1);
    do_start();
    feed(32'b1001, 4, 0);
    check("t4_keep_zpos", zm, 32'h8);
    do_abort();
    cfg_write(8'b101, 3, 1, 0);
    check("t4_err_clr", cfg_err, 0);
    do_start();
    feed(32'b10101, 5, 0);
    check("t4_zpos", zm, 32'h14);

    // Write during ARMED ignored; abort beats a match
    do_abort();
    cfg_write(8'b1001, 4, 0, 0);
    do_start();
    cfg_pattern = 8'b10; cfg_len = 4'd2; cfg_overlap = 0; cfg_target = 8'd1;
    cfg_we = 1;
    feed(32'b100, 3, 0);
    cfg_we = 0;
    check("t5_ignored_zpos", zm, 0);
    x = 1; x_valid = 1; abort = 1; cyc();
    check("t5_abort_z", last_z, 0);
    abort = 0; x_valid = 0;
    check("t5_cnt", match_count, 0);
    check("t5_busy", busy, 0);

    // Asynchronous reset mid-stream, then gapped stream
    do_start();
    feed(32'b1001, 4, 0);
    check("t6_cnt_pre", match_count, 1);
    feed(32'b10, 2, 0);
    #3 rst = 1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", match_count, 0);
    check("t6_rst_z", z, 0);
    check("t6_rst_done", done, 0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1 rst = 0;
    do_start();
    feed(32'b1001, 4, 3);
    check("t6_gap_zpos", zm, 32'h8);
    check("t6_gap_cnt", match_count, 1);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      cfg_we      = ($urandom % 16) == 0;
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 9));
      cfg_overlap = 1'($urandom);
      cfg_target  = 8'($urandom_range(0, 4));
      start       = ($urandom % 12) == 0;
      abort       = ($urandom % 40) == 0;
      x_valid     = ($urandom % 4) != 0;
      x           = 1'($urandom);
      cyc();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable controller for the serial Mealy sequence detector. It holds the pattern configuration and arms or stops detection. It counts matches and reports completion after a target number of matches. It sits between the host/config logic and the single-bit serial stream `x`, and lets one detector instance be reconfigured at run time for pattern, length and overlap mode.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of the match counter and target.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_we`, in, 1: configuration write strobe.
- `cfg_pattern`, in, MAX_LEN: pattern. Bit `[len-1]` is received first and bit `[0]` last.
- `cfg_len`, in, 4: pattern length. Legal range is 1..MAX_LEN.
- `cfg_overlap`, in, 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `cfg_target`, in, CNT_W: number of matches before done. 0 means run indefinitely.
- `start`, in, 1: arm detection.
- `abort`, in, 1: stop detection and return to IDLE.
- `x`, in, 1: serial data bit.
- `x_valid`, in, 1: `x` is sampled this cycle.
- `z`, out, 1: Mealy match output, combinational.
- `busy`, out, 1: high in ARMED.
- `done`, out, 1: high in DONE.
- `match_count`, out, CNT_W: matches since last start.
- `cfg_err`, out, 1: sticky; last config write was rejected.

## Operation
- Config registers reset to: pattern = `…1001`, len = 4, overlap = 0, target = 0.
- `cfg_we` is accepted only in IDLE or DONE. It is ignored in ARMED.
- A write with `cfg_len` = 0 or `cfg_len` > MAX_LEN is rejected:
  - The config registers are unchanged and `cfg_err` is set.
  - The next accepted write clears `cfg_err`.
- Detection state:
  - `hist`: MAX_LEN-1 bit shift register of past bits, newest in bit 0.
  - `fill`: count of valid history bits, saturating at MAX_LEN-1.
- Match condition `m`: `x_valid` AND `fill` ≥ len-1 AND `{hist[len-2:0], x}` == `pattern[len-1:0]`. For len = 1, `m` = `x_valid` AND (`x` == `pattern[0]`).
- `z` = (state == ARMED) AND `m` AND NOT `abort`. It is asserted in the same cycle as the last pattern bit (Mealy).
- On each `x_valid` cycle in ARMED:
  - `hist` shifts `x` in.
  - `fill` increments, saturating at MAX_LEN-1.
  - If `z` is high and overlap = 0, `fill` is cleared to 0 instead.
  - If `z` is high and overlap = 1, history is kept.
- `match_count` increments on each `z` and saturates at 2^CNT_W-1.

State machine:
- IDLE:
  - `start` → ARMED. `match_count`, `fill` and `hist` are cleared.
  - `abort` is a no-op.
- ARMED:
  - `abort` → IDLE. It has priority over a match in the same cycle: no `z`, no count.
  - If target ≠ 0 and `z` makes `match_count` + 1 == target → DONE.
  - `start` is ignored.
  - `x_valid` = 0 freezes all detection state.
- DONE:
  - `start` → ARMED with counters cleared.
  - `abort` → IDLE.
  - `match_count` holds.
- If `start` and `abort` are high together, `abort` wins.

## Timing
- Reset values: `z` = 0, `busy` = 0, `done` = 0, `match_count` = 0, `cfg_err` = 0, state IDLE, `hist`/`fill` = 0, config registers at their defaults.
- Reset mid-operation aborts immediately and asynchronously.
- `start` sampled at edge N → `busy` = 1 after edge N. The first bit that can be sampled is at edge N+1.
- `z` is valid combinationally during the cycle of the final bit. `match_count` reflects that match after the same edge.
- The target match at edge N → `done` = 1 and `busy` = 0 after edge N. A match in DONE is impossible because `z` is gated by ARMED.
- A config write takes effect at the edge it is sampled. A `start` in the following cycle uses the new config.
- There is no combinational path from `cfg_*` to `z`. The only combinational inputs to `z` are `x`, `x_valid` and `abort`.

## Test plan
- Default config, `start`, then stream 1,0,0,1,0,0,1,0,0,1,0,0,1,1,1,0,1,1 with `x_valid` = 1 every cycle → `z` on bits 3 and 9 (0-based), final `match_count` = 2, `done` = 0.
- Same stream with `cfg_overlap` = 1 → `z` on bits 3, 6, 9, 12, final `match_count` = 4.
- `cfg_target` = 2, overlap = 1, same stream → `done` after bit 6, `busy` = 0. Later bits give no `z`, and `match_count` stays 2.
- `cfg_len` = 0, then `cfg_len` = 9 with MAX_LEN = 8 → `cfg_err` = 1 and config unchanged. A write with len = 3 and pattern 101 → `cfg_err` = 0, and stream 1,0,1,0,1 with overlap = 1 gives `z` on bits 2 and 4.
- `abort` in the same cycle as the matching bit 3 → `z` = 0, `match_count` = 0, state IDLE. A `cfg_we` during ARMED is ignored.
- Assert `rst` mid-stream after one match → all outputs go to their reset values immediately. `x_valid` gaps of 3 cycles inside a pattern still yield a match.
